// File: rtl/uart_sender_if.sv
// uart_sender_if: byte-enqueue and serial-line bundle for uart_sender.
//   DATA  byte to enqueue (producer -> sender)
//   WR    enqueue strobe (producer -> sender)
//   FULL  transmit FIFO full (sender -> producer)
//   IDLE  nothing on the line and FIFO empty (sender -> producer)
//   TXD   registered 8N1 serial line, idle high (sender -> line)
interface uart_sender_if;
    logic [7:0] DATA;
    logic       WR;
    logic       FULL;
    logic       IDLE;
    logic       TXD;

    modport master (output DATA, WR, input FULL, IDLE, TXD);
    modport slave  (input DATA, WR, output FULL, IDLE, TXD);
endinterface

// File: rtl/uart_sender.sv
// uart_sender: 8N1 UART transmitter with a small transmit FIFO.
// Ports:
//   CLK  system clock, all state changes on its rising edge
//   RST  asynchronous active-high reset
//   bus  uart_sender_if.slave: DATA/WR enqueue side, FULL/IDLE status, TXD line
//
// state   | meaning
// S_IDLE  | line high, waiting for a queued byte
// S_START | driving the start bit (0)
// S_DATA  | driving data bits, LSB first
// S_STOP  | driving the stop bit (1)
module uart_sender #(
    parameter int CLKS_PER_BIT = 5000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    uart_sender_if.slave  bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             txd_q, txd_next;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    logic full, fifo_empty, wr_acc, pop, bit_done;

    // FULL comes straight from the registered count, so a write at the
    // same edge as a pop from a full FIFO is still refused.
    assign full       = (count == COUNT_FULL);
    assign fifo_empty = (count == '0);
    assign wr_acc     = bus.WR && !full;
    assign bit_done   = (baud_cnt == BAUD_LAST);

    assign bus.FULL = full;
    assign bus.IDLE = (state == S_IDLE) && fifo_empty;
    assign bus.TXD  = txd_q;

    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        txd_next     = txd_q;
        pop          = 1'b0;
        case (state)
            S_IDLE: begin
                txd_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr];
                    txd_next   = 1'b0;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_next   = S_DATA;
                    bit_idx_next = 3'd0;
                    txd_next     = shift_reg[0];
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                        txd_next   = 1'b1;
                    end else begin
                        // Current bit always sits in shift_reg[0]; shift and
                        // present the next one.
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        txd_next     = shift_reg[1];
                    end
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        // Back-to-back frame: no idle bit time between them.
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr];
                        txd_next   = 1'b0;
                        state_next = S_START;
                    end else begin
                        txd_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            txd_q     <= 1'b1;
        end else begin
            state     <= state_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            txd_q     <= txd_next;
            // Held at zero while idle, so a new frame always starts from 0;
            // every bit boundary coincides with the wrap.
            if (state == S_IDLE || bit_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            fifo_mem[wr_ptr] <= bus.DATA;
        end
    end
endmodule

// File: tb/tb_uart_sender.sv
// tb_uart_sender: directed self-checking bench for uart_sender
// (CLKS_PER_BIT=16, FIFO_DEPTH=4). The line and IDLE are recorded once per
// cycle just after each rising edge and compared against ideal 8N1 frames.
module tb_uart_sender;
    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;
    localparam int REC_MAX = 1024;

    logic clk;
    logic rst;

    uart_sender_if u_if ();

    uart_sender #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic rec_txd  [REC_MAX];
    logic rec_idle [REC_MAX];
    int   rec_n;
    logic [7:0] exp_bytes [8];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge, then record the settled line state.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rec_n < REC_MAX) begin
            rec_txd[rec_n]  = u_if.TXD;
            rec_idle[rec_n] = u_if.IDLE;
            rec_n++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // The write that starts the sequence lands on the edge recorded at
    // index 0, so the start bit must appear at index 1.
    task automatic check_line(input string tag, input int nexp);
        int f, idle_at, errs, zeros, idx;
        logic [7:0] got;
        logic exp_bit;
        f = -1;
        for (int i = 0; i < rec_n; i++)
            if (f < 0 && rec_txd[i] === 1'b0) f = i;
        chk({tag, "_fall"}, f, 1);
        if (f >= 0) begin
            for (int k = 0; k < nexp; k++) begin
                errs = 0;
                got  = '0;
                for (int j = 0; j < 10; j++) begin
                    for (int s = 0; s < CPB; s++) begin
                        exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_bytes[k][j-1];
                        idx = f + FRAME * k + CPB * j + s;
                        if (idx >= rec_n || rec_txd[idx] !== exp_bit) errs++;
                    end
                end
                for (int j = 0; j < 8; j++) begin
                    idx = f + FRAME * k + CPB * (j + 1) + CPB / 2;
                    if (idx < rec_n) got[j] = rec_txd[idx];
                end
                chk($sformatf("%s_byte%0d", tag, k), int'(got), int'(exp_bytes[k]));
                chk($sformatf("%s_wave%0d", tag, k), errs, 0);
            end
            idle_at = -1;
            for (int i = f; i < rec_n; i++)
                if (idle_at < 0 && rec_idle[i] === 1'b1) idle_at = i;
            chk({tag, "_idle_at"}, idle_at, f + FRAME * nexp);
            zeros = 0;
            for (int i = f + FRAME * nexp; i < rec_n; i++)
                if (rec_txd[i] !== 1'b1) zeros++;
            chk({tag, "_tail_low"}, zeros, 0);
        end
    endtask

    initial begin
        int quiet;
        rst = 1'b0;
        u_if.WR = 1'b0;
        u_if.DATA = 8'h00;
        rec_n = 0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_txd", int'(u_if.TXD), 1);
        chk("rst_idle", int'(u_if.IDLE), 1);
        chk("rst_full", int'(u_if.FULL), 0);
        ticks(3);
        rst = 1'b0;

        quiet = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (u_if.TXD !== 1'b1 || u_if.IDLE !== 1'b1) quiet++;
        end
        chk("quiet_200", quiet, 0);

        // Single 0x55 frame.
        rec_n = 0;
        u_if.DATA = 8'h55;
        u_if.WR = 1'b1;
        tick();
        u_if.WR = 1'b0;
        chk("single_txd_at_n", int'(u_if.TXD), 1);
        chk("single_idle_at_n", int'(u_if.IDLE), 0);
        ticks(190);
        exp_bytes[0] = 8'h55;
        check_line("single", 1);

        // Six-byte burst into a four-deep FIFO, then a write against a
        // full FIFO at the very edge that pops it.
        rec_n = 0;
        for (int d = 1; d <= 6; d++) begin
            u_if.DATA = 8'(d);
            u_if.WR = 1'b1;
            tick();
            if (d == 4) chk("burst_full_e4", int'(u_if.FULL), 0);
            if (d == 5) chk("burst_full_e5", int'(u_if.FULL), 1);
        end
        u_if.WR = 1'b0;
        chk("burst_full_e6", int'(u_if.FULL), 1);
        ticks(155);
        chk("burst_full_e161", int'(u_if.FULL), 1);
        u_if.DATA = 8'hEE;
        u_if.WR = 1'b1;
        tick();
        u_if.WR = 1'b0;
        chk("burst_full_pop", int'(u_if.FULL), 0);
        ticks(668);
        for (int k = 0; k < 5; k++) exp_bytes[k] = 8'(k + 1);
        check_line("burst", 5);

        // All-zero then all-one data.
        rec_n = 0;
        u_if.DATA = 8'h00;
        u_if.WR = 1'b1;
        tick();
        u_if.DATA = 8'hFF;
        tick();
        u_if.WR = 1'b0;
        ticks(340);
        exp_bytes[0] = 8'h00;
        exp_bytes[1] = 8'hFF;
        check_line("zero_ones", 2);

        // Reset in the middle of data bit 3 with two bytes queued.
        rec_n = 0;
        u_if.WR = 1'b1;
        u_if.DATA = 8'h00;
        tick();
        u_if.DATA = 8'h22;
        tick();
        u_if.DATA = 8'h33;
        tick();
        u_if.WR = 1'b0;
        ticks(69);
        chk("abort_bit3_txd", int'(u_if.TXD), 0);
        chk("abort_bit3_idle", int'(u_if.IDLE), 0);
        #2 rst = 1'b1;
        #1;
        chk("abort_txd", int'(u_if.TXD), 1);
        chk("abort_idle", int'(u_if.IDLE), 1);
        chk("abort_full", int'(u_if.FULL), 0);
        ticks(3);
        rst = 1'b0;
        ticks(20);
        chk("abort_after_txd", int'(u_if.TXD), 1);
        chk("abort_after_idle", int'(u_if.IDLE), 1);
        rec_n = 0;
        u_if.DATA = 8'hA3;
        u_if.WR = 1'b1;
        tick();
        u_if.WR = 1'b0;
        ticks(190);
        exp_bytes[0] = 8'hA3;
        check_line("after_rst", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_sender.md
UART_SENDER -- requirements
Module: uart_sender

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5000, clock cycles per bit time (48 MHz / 9600 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, >= 2).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port DATA  input  8  byte to enqueue.
REQ-006 SHALL have port WR  input  1  enqueue strobe, sampled at each rising edge.
REQ-007 SHALL have port FULL  output  1  FIFO holds FIFO_DEPTH entries.
REQ-008 SHALL have port IDLE  output  1  no frame on the line and FIFO empty.
REQ-009 SHALL have port TXD  output  1  serial line, registered, 8N1, idle high.

Function
REQ-010 SHALL frame each byte 8N1: one start bit (0), eight data bits LSB first, one stop bit (1); each bit held exactly CLKS_PER_BIT cycles; full frame = 10*CLKS_PER_BIT cycles.
REQ-011 SHALL accept a write when WR=1 and FULL=0 at the same edge, storing DATA at the FIFO tail.
REQ-012 SHALL ignore WR when FULL=1 at that edge; the byte is dropped and FIFO contents are unchanged, even if a pop occurs at the same edge.
REQ-013 SHALL allow a simultaneous accepted write and pop at one edge; count is then unchanged and the data are not corrupted.
REQ-014 SHALL run the FSM with states S_IDLE, S_START, S_DATA, S_STOP.
REQ-015 S_IDLE, FIFO non-empty: at the next edge, pop the head into the shift register, enter S_START, drive TXD=0, clear the baud counter.
REQ-016 S_START: after CLKS_PER_BIT cycles, enter S_DATA with bit index 0 and drive TXD = bit 0.
REQ-017 S_DATA: every CLKS_PER_BIT cycles, advance the bit index; after bit 7's period, enter S_STOP and drive TXD=1.
REQ-018 S_STOP: after CLKS_PER_BIT cycles, if FIFO non-empty, pop and enter S_START directly with no extra idle time; otherwise enter S_IDLE.
REQ-019 SHALL give latency of one edge: a write accepted at edge N into an empty FIFO while in S_IDLE makes TXD fall after edge N+1.
REQ-020 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap, with width ceil(log2(CLKS_PER_BIT)), 13 bits at default; bit index SHALL be 3 bits.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range 0..FIFO_DEPTH.
REQ-022 FULL SHALL be asserted exactly when count == FIFO_DEPTH, and SHALL be registered or derived from registered count only.
REQ-023 IDLE SHALL be 1 exactly when state == S_IDLE and count == 0.
REQ-024 TXD SHALL be glitch-free (flop output), and SHALL be 1 whenever state == S_IDLE.

Reset
REQ-025 RST=1 SHALL immediately (asynchronously) force TXD=1, IDLE=1, FULL=0, state S_IDLE, FIFO empty, all counters and the shift register 0.
REQ-026 RST asserted mid-frame SHALL abort the frame and discard the FIFO contents; no partial frame resumes after release.
REQ-027 After RST deasserts, the first accepted write SHALL behave per REQ-019.

Verification (bench uses CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-028 Reset pulse -> TXD=1, IDLE=1, FULL=0; no TXD transitions for 200 cycles with WR=0.
REQ-029 Single write 0x55 -> TXD after edge N+1 is 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles; IDLE returns 1 exactly 160 cycles after TXD falls.
REQ-030 WR=1 for 6 consecutive cycles with data 0x01..0x06 -> FULL=1 after the 5th edge; 0x06 is dropped; 0x01..0x05 are sent back-to-back in 800 cycles with no idle gap; FULL clears at the first subsequent pop.
REQ-031 FIFO full and stop bit ending, with WR=1 at the pop edge -> the byte is dropped, count=3 after the edge, and remaining order is preserved.
REQ-032 0x00 then 0xFF -> first frame is low for 144 cycles then high 16 cycles; second frame is low for 16 cycles then high 144 cycles.
REQ-033 RST asserted during data bit 3 with 2 bytes queued -> TXD=1 within the same cycle, IDLE=1; after release, a write of 0xA3 is sent correctly, and the queued bytes are never sent.
